// File: rtl/hex_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_scan_pkg                                              |
// | Purpose  : Shared constants and helpers for the hex scan controller. |
// |            SEG_BLANK - active-low pattern with every segment off     |
// |            CODE_ERR  - decoder code that renders the 'E' glyph       |
// |            cnt_width - ceil(log2(n)), minimum 1, for counter widths  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package hex_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] CODE_ERR  = 4'd10;

  // Smallest width able to hold 0..n-1; never returns less than 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scan_ctrl_hex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_scan_ctrl_hex                                         |
// | Purpose  : 4-bit code to seven-segment decoder, active-low outputs.  |
// |            Codes 0-9 give digit glyphs, 10 gives 'E', 11-15 blank.   |
// | Ports    : hex [3:0] in  - code to display                           |
// |            seg [6:0] out - segments {g,f,e,d,c,b,a}, 0 = lit         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hex_scan_ctrl_hex
  import hex_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      CODE_ERR: seg = 7'b0000110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_scan_ctrl                                             |
// | Purpose  : Time-multiplexed scan controller for a common-anode       |
// |            seven-segment display with a double-buffered value/mask.  |
// | Ports    : clk   in   system clock                                   |
// |            rst   in   asynchronous reset, active-high                |
// |            value in   4*DIGITS hex value, nibble 0 = rightmost digit |
// |            mask  in   DIGITS per-digit enable, 1 = lit               |
// |            load  in   strobe, captures value/mask into pending       |
// |            err   in   level, enabled digits show 'E'                 |
// |            an    out  anode select, active-low                       |
// |            seg   out  segments {g..a}, active-low                    |
// |            frame out  pulse after the scan wraps to digit 0          |
// | Options  : HEX_SCAN_LZB_EN enables leading-zero blanking.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     mask,
  input  logic                  load,
  input  logic                  err,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame
);

  localparam int CNT_W = cnt_width(REFRESH_DIV);
  localparam int IDX_W = cnt_width(DIGITS);

  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] c_one      = DIGITS'(1);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_pend_val;
  logic [DIGITS-1:0]   r_pend_mask;
  logic                r_pend_vld;
  logic [4*DIGITS-1:0] r_act_val;
  logic [DIGITS-1:0]   r_act_mask;

  logic                w_tick;
  logic                w_bound;
  logic                w_copy;
  logic [4*DIGITS-1:0] w_src_val;
  logic [DIGITS-1:0]   w_src_mask;
  logic [DIGITS-1:0]   w_en_mask;
  logic [3:0]          w_nib;
  logic [3:0]          w_code;
  logic [6:0]          w_dec_seg;
  logic [DIGITS-1:0]   w_an_nxt;
  logic [6:0]          w_seg_nxt;

  assign w_tick  = (r_cnt == c_cnt_last);
  assign w_bound = w_tick && (r_idx == c_idx_last);

  // A load on the boundary cycle bypasses pending and lands in active.
  assign w_copy     = w_bound && (load || r_pend_vld);
  assign w_src_val  = load ? value : r_pend_val;
  assign w_src_mask = load ? mask  : r_pend_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      frame       <= 1'b0;
      r_pend_val  <= '0;
      r_pend_mask <= '0;
      r_pend_vld  <= 1'b0;
      r_act_val   <= '0;
      r_act_mask  <= '0;
    end else begin
      frame <= w_bound;
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (load) begin
        r_pend_val  <= value;
        r_pend_mask <= mask;
      end

      if (w_copy) begin
        r_act_val  <= w_src_val;
        r_act_mask <= w_src_mask;
        r_pend_vld <= 1'b0;
      end else if (load) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

`ifdef HEX_SCAN_LZB_EN
  // Blank zero nibbles from the top digit down until the first nonzero one;
  // digit 0 always stays visible so a zero value still shows '0'.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] v);
    logic [DIGITS-1:0] res;
    logic              run;
    res = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (v[4*k +: 4] != 4'd0) run = 1'b0;
      if (run) res[k] = 1'b1;
    end
    return res;
  endfunction

  logic [DIGITS-1:0] r_lzb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lzb <= '0;
    end else if (w_copy) begin
      r_lzb <= lzb_mask(w_src_val);
    end
  end

  assign w_en_mask = err ? r_act_mask : (r_act_mask & ~r_lzb);
`else
  assign w_en_mask = r_act_mask;
`endif

  assign w_nib  = r_act_val[r_idx*4 +: 4];
  assign w_code = err ? CODE_ERR : w_nib;

  hex_scan_ctrl_hex u_hex (
    .hex (w_code),
    .seg (w_dec_seg)
  );

  // Slot count 0 is kept dark so the previous digit's segments never
  // bleed onto the newly selected anode.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    if ((r_cnt != '0) && w_en_mask[r_idx]) begin
      w_an_nxt  = ~(c_one << r_idx);
      w_seg_nxt = w_dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_hex_scan_ctrl                                          |
// | Purpose  : Directed self-checking bench for hex_scan_ctrl with       |
// |            DIGITS=8, REFRESH_DIV=4. Expected values follow the       |
// |            HEX_SCAN_LZB_EN setting used for the build.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_hex_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  mask;
  logic        load;
  logic        err;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame;

  int checks = 0;
  int errors = 0;

  hex_scan_ctrl #(
    .DIGITS      (8),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .mask  (mask),
    .load  (load),
    .err   (err),
    .an    (an),
    .seg   (seg),
    .frame (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] value;
    logic [7:0]  mask;
    logic        err;
    int          d;
    int          c;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [31:0] v, input logic [7:0] m,
                     input logic e, input int d, input int c,
                     input logic [7:0] ea, input logic [6:0] es);
    vec_t t;
    t.name = n; t.value = v; t.mask = m; t.err = e;
    t.d = d; t.c = c; t.exp_an = ea; t.exp_seg = es;
    vecs.push_back(t);
  endtask

  task automatic check_val(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_out(input string n, input logic [7:0] ea, input logic [6:0] es);
    checks++;
    if (an !== ea || seg !== es) begin
      errors++;
      $display("FAIL %s got an=%h seg=%h expected an=%h seg=%h", n, an, seg, ea, es);
    end
  endtask

  // Returns at the negedge where frame is high (cycle after the boundary).
  task automatic wait_frame(input string n);
    int k;
    k = 0;
    while (frame !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (frame !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s frame timeout got 0 expected 1", n);
    end
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] m);
    value = v;
    mask  = m;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Position 1+4*d+c after the frame negedge shows digit d, slot count c.
  task automatic run_vec(input vec_t t);
    err = t.err;
    pulse_load(t.value, t.mask);
    wait_frame(t.name);
    repeat (1 + 4 * t.d + t.c) @(negedge clk);
    check_out(t.name, t.exp_an, t.exp_seg);
  endtask

  initial begin
    int lit;
    rst = 1'b1; value = '0; mask = '0; load = 1'b0; err = 1'b0;

    add("d0c1_7",     32'h01234567, 8'hFF, 1'b0, 0, 1, 8'hFE, 7'h78);
    add("d0c0_blank", 32'h01234567, 8'hFF, 1'b0, 0, 0, 8'hFF, 7'h7F);
    add("d3c2_4",     32'h01234567, 8'hFF, 1'b0, 3, 2, 8'hF7, 7'h19);
    add("mask_d1",    32'h01234567, 8'hFD, 1'b0, 1, 2, 8'hFF, 7'h7F);
    add("mask_d2",    32'h01234567, 8'hFD, 1'b0, 2, 2, 8'hFB, 7'h12);
    add("err_d5",     32'h01234567, 8'hFF, 1'b1, 5, 1, 8'hDF, 7'h06);
    add("err_masked", 32'h01234567, 8'hFD, 1'b1, 1, 1, 8'hFF, 7'h7F);
    add("code_b",     32'h0000B000, 8'hFF, 1'b0, 3, 2, 8'hF7, 7'h7F);
    add("code_b_d0",  32'h0000B000, 8'hFF, 1'b0, 0, 1, 8'hFE, 7'h40);
    add("d7_8",       32'h89ABCDEF, 8'hFF, 1'b0, 7, 1, 8'h7F, 7'h00);
    add("d6_9",       32'h89ABCDEF, 8'hFF, 1'b0, 6, 2, 8'hBF, 7'h10);
    add("d1_code_e",  32'h89ABCDEF, 8'hFF, 1'b0, 1, 1, 8'hFD, 7'h7F);
    add("lz_d2",      32'h00000120, 8'hFF, 1'b0, 2, 1, 8'hFB, 7'h79);
    add("lz_d1",      32'h00000120, 8'hFF, 1'b0, 1, 1, 8'hFD, 7'h24);
    add("lz_d0",      32'h00000120, 8'hFF, 1'b0, 0, 1, 8'hFE, 7'h40);
    add("zero_d0",    32'h00000000, 8'hFF, 1'b0, 0, 1, 8'hFE, 7'h40);
    add("lz_err",     32'h00000120, 8'hFF, 1'b1, 7, 1, 8'h7F, 7'h06);
`ifdef HEX_SCAN_LZB_EN
    add("d7c3_0",     32'h01234567, 8'hFF, 1'b0, 7, 3, 8'hFF, 7'h7F);
    add("lz_d7",      32'h00000120, 8'hFF, 1'b0, 7, 1, 8'hFF, 7'h7F);
    add("lz_d3",      32'h00000120, 8'hFF, 1'b0, 3, 1, 8'hFF, 7'h7F);
    add("zero_d1",    32'h00000000, 8'hFF, 1'b0, 1, 1, 8'hFF, 7'h7F);
`else
    add("d7c3_0",     32'h01234567, 8'hFF, 1'b0, 7, 3, 8'h7F, 7'h40);
    add("lz_d7",      32'h00000120, 8'hFF, 1'b0, 7, 1, 8'h7F, 7'h40);
    add("lz_d3",      32'h00000120, 8'hFF, 1'b0, 3, 1, 8'hF7, 7'h40);
    add("zero_d1",    32'h00000000, 8'hFF, 1'b0, 1, 1, 8'hFD, 7'h40);
`endif

    // Reset state
    #12;
    check_out("reset_out", 8'hFF, 7'h7F);
    check_val("reset_frame", {31'd0, frame}, 32'd0);

    // First load: dark until the first frame, then digit 0 shows '7'
    @(negedge clk);
    rst = 1'b0;
    pulse_load(32'h01234567, 8'hFF);
    lit = 0;
    for (int k = 0; k < 100 && frame !== 1'b1; k++) begin
      if (an !== 8'hFF || seg !== 7'h7F) lit++;
      @(negedge clk);
    end
    check_val("dark_before_frame", lit, 0);
    wait_frame("first_frame");
    @(negedge clk);
    check_val("frame_one_cycle", {31'd0, frame}, 32'd0);
    check_out("first_d0c0", 8'hFF, 7'h7F);
    @(negedge clk);
    check_out("first_d0c1", 8'hFE, 7'h78);
    @(negedge clk);
    check_out("first_d0c2", 8'hFE, 7'h78);
    @(negedge clk);
    check_out("first_d0c3", 8'hFE, 7'h78);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Tear-free update: load during slot 3, old nibbles stay until the wrap
    err = 1'b0;
    pulse_load(32'h01234567, 8'hFF);
    wait_frame("tear_sync");
    repeat (15) @(negedge clk);
    pulse_load(32'h99999999, 8'hFF);
    repeat (7) @(negedge clk);
    check_out("tear_old_d5", 8'hDF, 7'h24);
    repeat (3) @(negedge clk);
    check_out("tear_old_d6", 8'hBF, 7'h79);
    wait_frame("tear_wrap");
    repeat (2) @(negedge clk);
    check_out("tear_new_d0", 8'hFE, 7'h10);

    // Several loads in one frame: the last one wins
    repeat (5) @(negedge clk);
    pulse_load(32'h11111111, 8'hFF);
    repeat (3) @(negedge clk);
    pulse_load(32'h22222222, 8'hFF);
    wait_frame("last_wins");
    repeat (2) @(negedge clk);
    check_out("last_wins_d0", 8'hFE, 7'h24);

    // Load on the boundary cycle is visible in that same slot 0
    repeat (29) @(negedge clk);
    pulse_load(32'h55555555, 8'hFF);
    check_val("bound_frame", {31'd0, frame}, 32'd1);
    repeat (2) @(negedge clk);
    check_out("bound_d0", 8'hFE, 7'h12);

    // Asynchronous reset between edges while digit 2 is lit
    wait_frame("arst_sync");
    repeat (11) @(negedge clk);
    check_out("arst_before", 8'hFB, 7'h12);
    #2 rst = 1'b1;
    #1;
    check_out("arst_dark", 8'hFF, 7'h7F);
    check_val("arst_frame", {31'd0, frame}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
